frame_drain_ctrl: RTL and testbench
===================================

FRAME_DRAIN_CTRL -- requirements
Module: frame_drain_ctrl

Interface
REQ-001 clk_sys  input  1  system clock; all logic on its rising edge.
REQ-002 rstn_sys  input  1  reset, asynchronous, active-low.
REQ-003 ptr_sfifo_empty  input  1  pointer FIFO empty flag.
REQ-004 ptr_sfifo_rd  output  1  pointer FIFO pop; dout valid one cycle later.
REQ-005 ptr_sfifo_dout  input  16  pointer word: [15] reserved 0, [14:11] one-hot source port, [10:0] frame length in bytes.
REQ-006 sfifo_rd  output  1  data FIFO pop; sfifo_dout valid one cycle later.
REQ-007 sfifo_dout  input  8  frame byte.
REQ-008 out_valid  output  1  out_data/out_sof/out_eof/out_src valid.
REQ-009 out_ready  input  1  downstream accepts byte when out_valid && out_ready.
REQ-010 out_data  output  8  frame byte.
REQ-011 out_sof / out_eof  output  1 each  first / last byte of frame.
REQ-012 out_src  output  4  one-hot source of current frame, stable for the whole frame.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 len_err_cnt  output  8  count of dropped zero-length pointers, saturating at 255.

Function
REQ-015 FSM states: IDLE, PTR_POP, PTR_CAP, DATA, DRAIN; one-hot encoded.
REQ-016 IDLE -> PTR_POP when !ptr_sfifo_empty; ptr_sfifo_rd high for exactly the PTR_POP cycle.
REQ-017 PTR_POP -> PTR_CAP unconditionally; PTR_CAP latches length [10:0] and source [14:11].
REQ-018 PTR_CAP: length 0 -> increment len_err_cnt, no data read, return to IDLE; else -> DATA.
REQ-019 DATA: issue counter loaded with length; sfifo_rd high when issue counter != 0 and (skid occupancy + in-flight reads) < 2; decrement on each rd.
REQ-020 Two-entry skid buffer captures sfifo_dout on the cycle after each sfifo_rd; no byte is lost or duplicated under any out_ready pattern.
REQ-021 out_valid = skid buffer not empty; head entry drives out_data; pops on out_valid && out_ready.
REQ-022 out_sof on byte index 0; out_eof on byte index length-1; both high for a 1-byte frame.
REQ-023 DATA -> DRAIN when issue counter reaches 0; DRAIN -> IDLE on the cycle the eof byte is accepted.
REQ-024 Unstalled throughput: one byte/cycle; first out_valid 4 cycles after ptr_sfifo_rd (PTR_POP, PTR_CAP, rd, capture).
REQ-025 Frame overhead: minimum 1 IDLE cycle between eof acceptance and next ptr_sfifo_rd.
REQ-026 out_valid held with stable payload while !out_ready; sfifo_rd never asserted when skid full.
REQ-027 Length 2047 (max 11-bit) supported; counters 11 bits, no wrap inside a frame.
REQ-028 ptr_sfifo_rd and sfifo_rd never high in the same cycle.

Reset
REQ-029 Asynchronous assert: FSM IDLE; ptr_sfifo_rd, sfifo_rd, out_valid, out_sof, out_eof, busy = 0; out_data, out_src = 0; len_err_cnt = 0; skid and counters cleared.
REQ-030 Reset mid-frame abandons the frame; no recovery of partial data; deassertion synchronous to clk_sys, first pop no earlier than 1 cycle after release.

Configuration
REQ-031 Macro FRAME_DRAIN_STATS_EN: defined -> adds output frame_cnt (64 bits, four 16-bit saturating per-source counters, index = source bit) incremented on eof acceptance; undefined -> port and counters absent, all other behaviour identical.

Verification
REQ-032 Pointer {src=0001,len=64}, out_ready=1 -> 64 bytes contiguous, sof on byte 0, eof on byte 63, out_src=0001, first out_valid 4 cycles after ptr_sfifo_rd.
REQ-033 Pointer len=1 -> single byte with sof=eof=1; FSM back to IDLE in 1 cycle after acceptance.
REQ-034 Pointer len=0 -> no sfifo_rd, len_err_cnt 0->1; 256 such pointers -> saturates at 255.
REQ-035 len=100, out_ready random 30% duty -> byte sequence matches sfifo order exactly, sfifo_rd count = 100, no rd while skid full.
REQ-036 rstn_sys low at byte 20 of a 60-byte frame -> all outputs 0 immediately; after release, next pointer processed normally.
REQ-037 FRAME_DRAIN_STATS_EN defined, frames from sources 0,2,2 -> frame_cnt fields {0,2,0,1} (src3..src0).

Source files
------------

// File: rtl/frame_drain_ctrl.sv
// Pops pointer words and streams each described frame from the data FIFO through a 2-entry skid buffer.
// Optional per-source frame counters are enabled with FRAME_DRAIN_STATS_EN.
module frame_drain_ctrl (
  input  logic        clk_sys,
  input  logic        rstn_sys,
  input  logic        ptr_sfifo_empty,
  output logic        ptr_sfifo_rd,
  input  logic [15:0] ptr_sfifo_dout,
  output logic        sfifo_rd,
  input  logic [7:0]  sfifo_dout,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_sof,
  output logic        out_eof,
  output logic [3:0]  out_src,
  output logic        busy,
  output logic [7:0]  len_err_cnt
`ifdef FRAME_DRAIN_STATS_EN
  ,
  output logic [63:0] frame_cnt
`endif
);

  localparam int unsigned LEN_W  = 11;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned SRC_W  = 4;
  localparam int unsigned ERR_W  = 8;
  localparam int unsigned STAT_W = 16;

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    PTR_POP = 5'b00010,
    PTR_CAP = 5'b00100,
    DATA    = 5'b01000,
    DRAIN   = 5'b10000
  } state_t;

  state_t             state;
  logic [LEN_W-1:0]   frame_len;
  logic [LEN_W-1:0]   issue_cnt;
  logic [LEN_W-1:0]   cap_idx;
  logic               cap_vld;
  logic               pop;
  logic               cap_sof;
  logic               cap_eof;
  logic [1:0]         occ;
  logic [1:0]         reserved;
  logic [DATA_W-1:0]  ent1_data;
  logic               ent1_sof;
  logic               ent1_eof;
  logic               ent1_vld;
  logic [LEN_W-1:0]   ptr_len;
  logic [SRC_W-1:0]   ptr_src;
  logic               ptr_rsvd_unused;

  assign ptr_len         = ptr_sfifo_dout[10:0];
  assign ptr_src         = ptr_sfifo_dout[14:11];
  assign ptr_rsvd_unused = ptr_sfifo_dout[15];

  // Read credit counts the byte leaving this cycle so an unstalled frame streams at full rate.
  always_comb begin
    pop      = out_valid && out_ready;
    occ      = 2'(out_valid) + 2'(ent1_vld);
    reserved = occ - 2'(pop) + 2'(cap_vld);
    sfifo_rd = (state == DATA) && (issue_cnt != '0) && !ent1_vld && (reserved < 2'd2);
    cap_sof  = (cap_idx == '0);
    cap_eof  = (cap_idx == frame_len - LEN_W'(1));
  end

  // Frame sequencing: pointer pop, capture, data issue, drain to eof.
  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      state        <= IDLE;
      ptr_sfifo_rd <= 1'b0;
      busy         <= 1'b0;
      frame_len    <= '0;
      out_src      <= '0;
      issue_cnt    <= '0;
      len_err_cnt  <= '0;
    end else begin
      ptr_sfifo_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (!ptr_sfifo_empty) begin
            state        <= PTR_POP;
            ptr_sfifo_rd <= 1'b1;
            busy         <= 1'b1;
          end
        end
        PTR_POP: state <= PTR_CAP;
        PTR_CAP: begin
          frame_len <= ptr_len;
          out_src   <= ptr_src;
          issue_cnt <= ptr_len;
          if (ptr_len == '0) begin
            if (len_err_cnt != '1) len_err_cnt <= len_err_cnt + ERR_W'(1);
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state <= DATA;
          end
        end
        DATA: begin
          if (sfifo_rd) begin
            issue_cnt <= issue_cnt - LEN_W'(1);
            if (issue_cnt == LEN_W'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && out_eof) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Skid buffer: head entry is the output register, entry 1 holds the overflow byte.
  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      cap_vld   <= 1'b0;
      cap_idx   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      ent1_vld  <= 1'b0;
      ent1_data <= '0;
      ent1_sof  <= 1'b0;
      ent1_eof  <= 1'b0;
    end else begin
      cap_vld <= sfifo_rd;
      if (state == PTR_CAP) cap_idx <= '0;
      else if (cap_vld)     cap_idx <= cap_idx + LEN_W'(1);
      case ({cap_vld, pop})
        2'b10: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= sfifo_dout;
            out_sof   <= cap_sof;
            out_eof   <= cap_eof;
          end else begin
            ent1_vld  <= 1'b1;
            ent1_data <= sfifo_dout;
            ent1_sof  <= cap_sof;
            ent1_eof  <= cap_eof;
          end
        end
        2'b01: begin
          if (ent1_vld) begin
            out_data <= ent1_data;
            out_sof  <= ent1_sof;
            out_eof  <= ent1_eof;
            ent1_vld <= 1'b0;
          end else begin
            out_valid <= 1'b0;
          end
        end
        2'b11: begin
          if (ent1_vld) begin
            out_data  <= ent1_data;
            out_sof   <= ent1_sof;
            out_eof   <= ent1_eof;
            ent1_data <= sfifo_dout;
            ent1_sof  <= cap_sof;
            ent1_eof  <= cap_eof;
          end else begin
            out_data <= sfifo_dout;
            out_sof  <= cap_sof;
            out_eof  <= cap_eof;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef FRAME_DRAIN_STATS_EN
  // Saturating completed-frame count per source bit, bumped when the eof byte is taken.
  always_ff @(posedge clk_sys or negedge rstn_sys) begin
    if (!rstn_sys) begin
      frame_cnt <= '0;
    end else if (pop && out_eof) begin
      for (int i = 0; i < SRC_W; i++) begin
        if (out_src[i] && (frame_cnt[i*STAT_W +: STAT_W] != '1))
          frame_cnt[i*STAT_W +: STAT_W] <= frame_cnt[i*STAT_W +: STAT_W] + STAT_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_frame_drain_ctrl.sv
// Self-checking bench for frame_drain_ctrl: FIFO models, random bytes/backpressure, scoreboard of expected frames.
module tb_frame_drain_ctrl;

  logic        clk_sys = 1'b0;
  logic        rstn_sys;
  logic        ptr_sfifo_empty;
  logic        ptr_sfifo_rd;
  logic [15:0] ptr_sfifo_dout;
  logic        sfifo_rd;
  logic [7:0]  sfifo_dout;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_sof;
  logic        out_eof;
  logic [3:0]  out_src;
  logic        busy;
  logic [7:0]  len_err_cnt;
`ifdef FRAME_DRAIN_STATS_EN
  logic [63:0] frame_cnt;
`endif

  always #5 clk_sys = ~clk_sys;

  frame_drain_ctrl dut (
    .clk_sys         (clk_sys),
    .rstn_sys        (rstn_sys),
    .ptr_sfifo_empty (ptr_sfifo_empty),
    .ptr_sfifo_rd    (ptr_sfifo_rd),
    .ptr_sfifo_dout  (ptr_sfifo_dout),
    .sfifo_rd        (sfifo_rd),
    .sfifo_dout      (sfifo_dout),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .out_sof         (out_sof),
    .out_eof         (out_eof),
    .out_src         (out_src),
    .busy            (busy),
    .len_err_cnt     (len_err_cnt)
`ifdef FRAME_DRAIN_STATS_EN
    ,
    .frame_cnt       (frame_cnt)
`endif
  );

  typedef struct packed {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic [3:0] src;
  } exp_t;

  logic [15:0] ptr_q[$];
  logic [7:0]  data_q[$];
  exp_t        exp_q[$];

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ready_pct = 100;
  int   rd_total, acc_total;
  bit   rd_prev, prev_stall, check_gap, s_busy;
  logic [14:0] prev_payload;
  int   n_acc, rd_cnt, t_prd, t_first_valid, t_first_acc, t_eof, t_idle, last_eof;
  int   err_exp;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input logic [3:0] src, input int len);
    exp_t e;
    logic [7:0] b;
    ptr_q.push_back({1'b0, src, 11'(len)});
    ptr_sfifo_empty = 1'b0;
    if (len == 0) err_exp = (err_exp < 255) ? err_exp + 1 : 255;
    for (int i = 0; i < len; i++) begin
      b      = 8'($urandom);
      e.data = b;
      e.sof  = (i == 0);
      e.eof  = (i == len - 1);
      e.src  = src;
      data_q.push_back(b);
      exp_q.push_back(e);
    end
  endtask

  // One clock: drive ready on negedge, sample and score, then model FIFO pops after posedge.
  task automatic step();
    exp_t e;
    int   skid;
    bit   rd_now, prd_now;
    @(negedge clk_sys);
    out_ready = ($urandom_range(99, 0) < ready_pct);
    #1;
    s_busy = busy;
    skid   = rd_total - int'(rd_prev) - acc_total;
    chk("valid_vs_skid", 64'(out_valid), 64'(skid != 0));
    if (prev_stall)
      chk("hold_payload", 64'({out_valid, out_data, out_sof, out_eof, out_src}), 64'(prev_payload));
    if (sfifo_rd) begin
      chk("rd_while_full", 64'(skid >= 2), 64'(0));
      chk("rd_exclusive", 64'(ptr_sfifo_rd), 64'(0));
      rd_cnt++;
    end
    if (ptr_sfifo_rd) begin
      t_prd = cyc;
      if (check_gap && last_eof >= 0) chk("eof_to_ptr_gap", 64'(cyc - last_eof), 64'(2));
    end
    if (out_valid && t_first_valid < 0) t_first_valid = cyc;
    if (!busy && t_eof >= 0 && t_idle < 0 && cyc > t_eof) t_idle = cyc;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("extra_byte", 64'(exp_q.size()), 64'(1));
      end else begin
        e = exp_q.pop_front();
        chk("byte", 64'({out_data, out_sof, out_eof, out_src}), 64'(e));
        if (t_first_acc < 0) t_first_acc = cyc;
        n_acc++;
        if (e.eof) begin
          t_eof    = cyc;
          last_eof = cyc;
        end
      end
      acc_total++;
    end
    prev_stall   = out_valid && !out_ready;
    prev_payload = {out_valid, out_data, out_sof, out_eof, out_src};
    rd_now  = sfifo_rd;
    prd_now = ptr_sfifo_rd;
    @(posedge clk_sys);
    #1;
    rd_total += int'(rd_now);
    rd_prev   = rd_now;
    if (prd_now) begin
      if (ptr_q.size() == 0) chk("ptr_pop_empty", 64'(ptr_q.size()), 64'(1));
      else ptr_sfifo_dout = ptr_q.pop_front();
    end
    if (rd_now) begin
      if (data_q.size() == 0) chk("data_pop_empty", 64'(data_q.size()), 64'(1));
      else sfifo_dout = data_q.pop_front();
    end
    ptr_sfifo_empty = (ptr_q.size() == 0);
    cyc++;
  endtask

  task automatic run(input int budget, input int stop_acc);
    int n;
    n = 0; n_acc = 0; rd_cnt = 0;
    t_prd = -1; t_first_valid = -1; t_first_acc = -1; t_eof = -1; t_idle = -1;
    do begin
      step();
      n++;
    end while (!(ptr_q.size() == 0 && exp_q.size() == 0 && !s_busy) && n < budget &&
               !(stop_acc > 0 && n_acc == stop_acc));
    total++;
    assert (n < budget) else begin
      bad++;
      $error("FAIL timeout observed=%0d expected<%0d", n, budget);
    end
  endtask

  task automatic clear_model();
    ptr_q.delete(); data_q.delete(); exp_q.delete();
    rd_total = 0; acc_total = 0; rd_prev = 0; prev_stall = 0;
    ptr_sfifo_empty = 1'b1;
  endtask

  initial begin
    int sum;
    rstn_sys = 1'b0; out_ready = 1'b0; ptr_sfifo_empty = 1'b1;
    ptr_sfifo_dout = '0; sfifo_dout = '0;
    err_exp = 0; last_eof = -1; check_gap = 0;
    clear_model();
    #2;
    chk("rst_ptr_rd", 64'(ptr_sfifo_rd), 64'(0));
    chk("rst_sfifo_rd", 64'(sfifo_rd), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_sof_eof", 64'({out_sof, out_eof}), 64'(0));
    chk("rst_data_src", 64'({out_data, out_src}), 64'(0));
    chk("rst_len_err", 64'(len_err_cnt), 64'(0));
    repeat (2) step();
    rstn_sys = 1'b1;
    repeat (2) step();

    // 64-byte frame, no backpressure
    ready_pct = 100;
    push_frame(4'b0001, 64);
    run(400, 0);
    chk("f64_latency", 64'(t_first_valid - t_prd), 64'(4));
    chk("f64_count", 64'(n_acc), 64'(64));
    chk("f64_contig", 64'(t_eof - t_first_acc), 64'(63));
    chk("f64_rd_cnt", 64'(rd_cnt), 64'(64));
    chk("f64_idle", 64'(t_idle - t_eof), 64'(1));

    // single-byte frame
    push_frame(4'b1000, 1);
    run(100, 0);
    chk("f1_latency", 64'(t_first_valid - t_prd), 64'(4));
    chk("f1_count", 64'(n_acc), 64'(1));
    chk("f1_idle", 64'(t_idle - t_eof), 64'(1));

    // zero-length pointers, then saturation
    push_frame(4'b0010, 0);
    run(100, 0);
    chk("zl_rd_cnt", 64'(rd_cnt), 64'(0));
    chk("zl_err_one", 64'(len_err_cnt), 64'(err_exp));
    for (int i = 0; i < 255; i++) push_frame(4'b0010, 0);
    run(3000, 0);
    chk("zl_err_sat", 64'(len_err_cnt), 64'(err_exp));

    // 100 bytes under 30% ready
    ready_pct = 30;
    push_frame(4'b0100, 100);
    run(2000, 0);
    chk("f100_rd_cnt", 64'(rd_cnt), 64'(100));
    chk("f100_count", 64'(n_acc), 64'(100));

    // random frames, random backpressure
    ready_pct = $urandom_range(90, 20);
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      int len;
      len = $urandom_range(48, 1);
      sum += len;
      push_frame(4'b0001 << $urandom_range(3, 0), len);
    end
    run(4000, 0);
    chk("rand_count", 64'(n_acc), 64'(sum));
    chk("rand_rd_cnt", 64'(rd_cnt), 64'(sum));

    // back-to-back frames: one idle cycle between eof and the next pointer pop
    ready_pct = 100; check_gap = 1; last_eof = -1;
    push_frame(4'b0010, 3); push_frame(4'b1000, 1); push_frame(4'b0001, 5);
    run(200, 0);
    check_gap = 0;
    chk("b2b_count", 64'(n_acc), 64'(9));

    // maximum length
    push_frame(4'b0100, 2047);
    run(2200, 0);
    chk("fmax_count", 64'(n_acc), 64'(2047));
    chk("fmax_rd_cnt", 64'(rd_cnt), 64'(2047));
    chk("fmax_contig", 64'(t_eof - t_first_acc), 64'(2046));

    // reset in the middle of a 60-byte frame
    ready_pct = 70;
    push_frame(4'b0100, 60);
    run(1000, 20);
    chk("mid_acc", 64'(n_acc), 64'(20));
    rstn_sys = 1'b0;
    #1;
    chk("mrst_ptr_rd", 64'(ptr_sfifo_rd), 64'(0));
    chk("mrst_sfifo_rd", 64'(sfifo_rd), 64'(0));
    chk("mrst_out_valid", 64'(out_valid), 64'(0));
    chk("mrst_busy", 64'(busy), 64'(0));
    chk("mrst_sof_eof", 64'({out_sof, out_eof}), 64'(0));
    chk("mrst_data_src", 64'({out_data, out_src}), 64'(0));
    chk("mrst_len_err", 64'(len_err_cnt), 64'(0));
    clear_model();
    err_exp = 0;
    repeat (2) step();
    rstn_sys = 1'b1;
    step();

    // frames from sources 0, 2, 2 after reset, then one zero-length pointer
    ready_pct = 100;
    push_frame(4'b0001, 5);
    run(100, 0);
    chk("post_rst_latency", 64'(t_first_valid - t_prd), 64'(4));
    chk("post_rst_count", 64'(n_acc), 64'(5));
    push_frame(4'b0100, 7); push_frame(4'b0100, 3);
    run(200, 0);
    chk("post_rst_src2", 64'(n_acc), 64'(10));
`ifdef FRAME_DRAIN_STATS_EN
    chk("frame_cnt", frame_cnt, 64'h0000_0002_0000_0001);
`endif
    push_frame(4'b1000, 0);
    run(100, 0);
    chk("post_rst_err", 64'(len_err_cnt), 64'(err_exp));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
